// File: rtl/alu_control_sequencer.sv
// Fetch/decode/execute sequencer driving the 8-bit ALU control side.
// Multi-cycle FSM: FETCH -> DECODE -> EXEC -> (WB) -> FETCH, with a terminal HALT.
module alu_control_sequencer #(
  parameter int unsigned     PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  input  logic            cy,
  input  logic            zy,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  output logic            en_alu,
  output logic [4:0]      aluop,
  output logic [2:0]      rd_addr,
  output logic [2:0]      ra_addr,
  output logic [7:0]      imm,
  output logic            imm_sel,
  output logic            reg_we,
  output logic            illegal_op,
  output logic            halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {K_ALU, K_BRZ, K_BRCS, K_RJMP, K_HALT, K_ILL} kind_t;

  state_t          state;
  kind_t           kind, dec_kind;
  logic            wb_q, dec_wb, dec_sel;
  logic [4:0]      op, dec_aluop;
  logic [PC_W-1:0] pc_inc, pc_tgt;

  assign op     = instr[15:11];
  assign pc_inc = pc + PC_W'(1);
  assign pc_tgt = pc_inc + PC_W'($signed(imm));

  always_comb begin
    dec_kind  = K_ILL;
    dec_aluop = '0;
    dec_sel   = 1'b0;
    dec_wb    = 1'b0;
    if (op <= 5'b01111 || op == 5'b11110) begin
      dec_kind  = K_ALU;
      dec_aluop = op;
      dec_wb    = (op != 5'b00000) && (op != 5'b01011);
    end else begin
      case (op)
        5'b10000: begin
          dec_kind  = K_ALU;
          dec_aluop = 5'b11110;
          dec_sel   = 1'b1;
          dec_wb    = 1'b1;
        end
        5'b10001: begin
          dec_kind  = K_ALU;
          dec_aluop = 5'b01011;
          dec_sel   = 1'b1;
        end
        5'b10010: dec_kind = K_BRZ;
        5'b10011: dec_kind = K_BRCS;
        5'b10100: dec_kind = K_RJMP;
        5'b11111: dec_kind = K_HALT;
        default:  dec_kind = K_ILL;
      endcase
    end
  end

  // Outputs are registered: each is loaded on the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      kind       <= K_ALU;
      wb_q       <= 1'b0;
      pc         <= RST_PC;
      instr_req  <= 1'b0;
      en_alu     <= 1'b0;
      reg_we     <= 1'b0;
      illegal_op <= 1'b0;
      halted     <= 1'b0;
      imm_sel    <= 1'b0;
      aluop      <= '0;
      rd_addr    <= '0;
      ra_addr    <= '0;
      imm        <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          // First cycle after reset only raises the request; valid is ignored until then.
          if (instr_req && instr_valid) begin
            instr_req <= 1'b0;
            rd_addr   <= instr[10:8];
            ra_addr   <= instr[7:5];
            imm       <= instr[7:0];
            imm_sel   <= dec_sel;
            aluop     <= dec_aluop;
            kind      <= dec_kind;
            wb_q      <= dec_wb;
            state     <= S_DECODE;
          end else begin
            instr_req <= 1'b1;
          end
        end
        S_DECODE: begin
          en_alu     <= (kind == K_ALU);
          illegal_op <= (kind == K_ILL);
          state      <= S_EXEC;
        end
        S_EXEC: begin
          en_alu     <= 1'b0;
          illegal_op <= 1'b0;
          case (kind)
            K_ALU: begin
              reg_we <= wb_q;
              state  <= S_WB;
            end
            K_BRZ, K_BRCS, K_RJMP: begin
              if ((kind == K_RJMP) || (kind == K_BRZ && zy) || (kind == K_BRCS && cy))
                pc <= pc_tgt;
              else
                pc <= pc_inc;
              instr_req <= 1'b1;
              state     <= S_FETCH;
            end
            K_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              pc        <= pc_inc;
              instr_req <= 1'b1;
              state     <= S_FETCH;
            end
          endcase
        end
        S_WB: begin
          reg_we    <= 1'b0;
          pc        <= pc_inc;
          instr_req <= 1'b1;
          state     <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: latency, decode fields, branches, wrap, stall, halt, reset.
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        cy = 1'b0;
  logic        zy = 1'b0;
  logic        instr_req, en_alu, imm_sel, reg_we, illegal_op, halted;
  logic [7:0]  pc, imm;
  logic [4:0]  aluop;
  logic [2:0]  rd_addr, ra_addr;

  int tests = 0;
  int fails = 0;

  logic [12:1] h_en, h_we, h_ill, h_sel;
  logic [4:0]  h_aluop [1:12];
  logic [2:0]  h_rd    [1:12];
  logic [2:0]  h_ra    [1:12];
  logic [7:0]  h_imm   [1:12];

  alu_control_sequencer #(.PC_W(8), .RST_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .cy(cy), .zy(zy), .instr_req(instr_req), .pc(pc), .en_alu(en_alu),
    .aluop(aluop), .rd_addr(rd_addr), .ra_addr(ra_addr), .imm(imm),
    .imm_sel(imm_sel), .reg_we(reg_we), .illegal_op(illegal_op), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic snap(input int c);
    h_en[c]    = en_alu;
    h_we[c]    = reg_we;
    h_ill[c]   = illegal_op;
    h_sel[c]   = imm_sel;
    h_aluop[c] = aluop;
    h_rd[c]    = rd_addr;
    h_ra[c]    = ra_addr;
    h_imm[c]   = imm;
  endtask

  // Issues one instruction from FETCH and records outputs per cycle until the next FETCH or HALT.
  task automatic run_instr(input logic [15:0] w, output int cyc);
    int n = 0;
    h_en = '0; h_we = '0; h_ill = '0; h_sel = '0;
    while (instr_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    instr = w;
    instr_valid = 1'b1;
    cyc = 1;
    snap(1);
    do begin
      @(negedge clk);
      if (instr_req === 1'b1 || halted === 1'b1) break;
      cyc++;
      snap(cyc);
    end while (cyc < 12);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({en_alu, reg_we, illegal_op, halted, imm_sel, instr_req} !== 6'b0)
      begin fails++; $display("FAIL reset_ctrl: got %b expected 000000", {en_alu, reg_we, illegal_op, halted, imm_sel, instr_req}); end
    tests++;
    if (pc !== 8'h00) begin fails++; $display("FAIL reset_pc: got %h expected 00", pc); end
    tests++;
    if ({aluop, rd_addr, ra_addr, imm} !== 19'b0)
      begin fails++; $display("FAIL reset_fields: got %h expected 0", {aluop, rd_addr, ra_addr, imm}); end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (instr_req !== 1'b1) begin fails++; $display("FAIL req_after_reset: got %b expected 1", instr_req); end
  endtask

  task automatic test_add;
    int cyc;
    run_instr(16'h0A40, cyc);
    tests++;
    if (cyc !== 4) begin fails++; $display("FAIL add_latency: got %0d expected 4", cyc); end
    tests++;
    if (h_en !== 12'h004) begin fails++; $display("FAIL add_en_alu: got %h expected 004", h_en); end
    tests++;
    if (h_aluop[3] !== 5'b00001) begin fails++; $display("FAIL add_aluop: got %b expected 00001", h_aluop[3]); end
    tests++;
    if (h_we !== 12'h008) begin fails++; $display("FAIL add_reg_we: got %h expected 008", h_we); end
    tests++;
    if (h_rd[4] !== 3'd2 || h_ra[3] !== 3'd2)
      begin fails++; $display("FAIL add_addr: got rd=%0d ra=%0d expected rd=2 ra=2", h_rd[4], h_ra[3]); end
    tests++;
    if (h_sel !== 12'h000) begin fails++; $display("FAIL add_imm_sel: got %h expected 000", h_sel); end
    tests++;
    if (pc !== 8'h01) begin fails++; $display("FAIL add_pc: got %h expected 01", pc); end
  endtask

  task automatic test_ldi_cpi;
    int cyc;
    run_instr(16'h853C, cyc);
    tests++;
    if (h_sel[2] !== 1'b1 || h_imm[2] !== 8'h3C || h_rd[2] !== 3'd5)
      begin fails++; $display("FAIL ldi_decode: got sel=%b imm=%h rd=%0d expected sel=1 imm=3c rd=5", h_sel[2], h_imm[2], h_rd[2]); end
    tests++;
    if (h_aluop[3] !== 5'b11110 || h_en !== 12'h004)
      begin fails++; $display("FAIL ldi_alu: got op=%b en=%h expected op=11110 en=004", h_aluop[3], h_en); end
    tests++;
    if (h_we !== 12'h008 || cyc !== 4)
      begin fails++; $display("FAIL ldi_wb: got we=%h cyc=%0d expected we=008 cyc=4", h_we, cyc); end
    run_instr(16'h8D3C, cyc);
    tests++;
    if (h_aluop[3] !== 5'b01011 || h_en !== 12'h004 || h_sel[3] !== 1'b1)
      begin fails++; $display("FAIL cpi_alu: got op=%b en=%h sel=%b expected op=01011 en=004 sel=1", h_aluop[3], h_en, h_sel[3]); end
    tests++;
    if (h_we !== 12'h000) begin fails++; $display("FAIL cpi_no_wb: got %h expected 000", h_we); end
    tests++;
    if (pc !== 8'h03) begin fails++; $display("FAIL cpi_pc: got %h expected 03", pc); end
  endtask

  task automatic test_branch;
    int cyc;
    run_instr(16'hA00C, cyc);
    tests++;
    if (pc !== 8'h10 || cyc !== 3) begin fails++; $display("FAIL rjmp_fwd: got pc=%h cyc=%0d expected pc=10 cyc=3", pc, cyc); end
    zy = 1'b1; cy = 1'b0;
    run_instr(16'h90FE, cyc);
    tests++;
    if (pc !== 8'h0F) begin fails++; $display("FAIL brz_taken: got %h expected 0f", pc); end
    tests++;
    if (cyc !== 3 || h_en !== 12'h000 || h_we !== 12'h000)
      begin fails++; $display("FAIL brz_timing: got cyc=%0d en=%h we=%h expected cyc=3 en=000 we=000", cyc, h_en, h_we); end
    run_instr(16'hA000, cyc);
    zy = 1'b0; cy = 1'b1;
    run_instr(16'h90FE, cyc);
    tests++;
    if (pc !== 8'h11) begin fails++; $display("FAIL brz_not_taken: got %h expected 11", pc); end
    run_instr(16'hA0FE, cyc);
    tests++;
    if (pc !== 8'h10) begin fails++; $display("FAIL rjmp_back: got %h expected 10", pc); end
    run_instr(16'h9805, cyc);
    tests++;
    if (pc !== 8'h16) begin fails++; $display("FAIL brcs_taken: got %h expected 16", pc); end
    cy = 1'b0;
  endtask

  task automatic test_wrap;
    int cyc;
    run_instr(16'hA0E8, cyc);
    tests++;
    if (pc !== 8'hFF) begin fails++; $display("FAIL reach_ff: got %h expected ff", pc); end
    run_instr(16'hA002, cyc);
    tests++;
    if (pc !== 8'h02) begin fails++; $display("FAIL rjmp_wrap: got %h expected 02", pc); end
    run_instr(16'hA0FC, cyc);
    run_instr(16'h0000, cyc);
    tests++;
    if (pc !== 8'h00) begin fails++; $display("FAIL nop_wrap: got %h expected 00", pc); end
    tests++;
    if (cyc !== 4 || h_en !== 12'h004 || h_we !== 12'h000)
      begin fails++; $display("FAIL nop_strobes: got cyc=%0d en=%h we=%h expected cyc=4 en=004 we=000", cyc, h_en, h_we); end
  endtask

  task automatic test_stall_illegal;
    int cyc;
    logic [7:0] pc0;
    pc0 = pc;
    instr = 16'h0A40;
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (instr_req !== 1'b1 || {en_alu, reg_we, illegal_op} !== 3'b0 || pc !== pc0)
        begin fails++; $display("FAIL stall_%0d: got req=%b strobes=%b pc=%h expected req=1 strobes=000 pc=%h", i, instr_req, {en_alu, reg_we, illegal_op}, pc, pc0); end
    end
    run_instr(16'hA800, cyc);
    tests++;
    if (h_ill !== 12'h004 || h_en !== 12'h000 || h_we !== 12'h000)
      begin fails++; $display("FAIL illegal_pulse: got ill=%h en=%h we=%h expected ill=004 en=000 we=000", h_ill, h_en, h_we); end
    tests++;
    if (pc !== pc0 + 8'h01 || cyc !== 3)
      begin fails++; $display("FAIL illegal_pc: got pc=%h cyc=%0d expected pc=%h cyc=3", pc, cyc, pc0 + 8'h01); end
    tests++;
    if (illegal_op !== 1'b0) begin fails++; $display("FAIL illegal_clear: got %b expected 0", illegal_op); end
  endtask

  task automatic test_halt;
    int cyc;
    logic [7:0] pc0;
    pc0 = pc;
    run_instr(16'hF800, cyc);
    tests++;
    if (cyc !== 3 || halted !== 1'b1) begin fails++; $display("FAIL halt_entry: got cyc=%0d halted=%b expected cyc=3 halted=1", cyc, halted); end
    instr_valid = 1'b1;
    instr = 16'h0A40;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (halted !== 1'b1 || instr_req !== 1'b0 || pc !== pc0 || {en_alu, reg_we, illegal_op} !== 3'b0)
        begin fails++; $display("FAIL halt_hold_%0d: got halted=%b req=%b pc=%h strobes=%b expected 1 0 %h 000", i, halted, instr_req, pc, {en_alu, reg_we, illegal_op}, pc0); end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_exec;
    int cyc;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_instr(16'h0000, cyc);
    tests++;
    if (pc !== 8'h01 || halted !== 1'b0) begin fails++; $display("FAIL post_halt_reset: got pc=%h halted=%b expected pc=01 halted=0", pc, halted); end
    instr = 16'h0A40;
    instr_valid = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (en_alu !== 1'b1) begin fails++; $display("FAIL mid_exec_en: got %b expected 1", en_alu); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({en_alu, reg_we, instr_req} !== 3'b0 || pc !== 8'h00)
      begin fails++; $display("FAIL mid_exec_reset: got en=%b we=%b req=%b pc=%h expected 0 0 0 00", en_alu, reg_we, instr_req, pc); end
    rst = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (instr_req !== 1'b1 || reg_we !== 1'b0) begin fails++; $display("FAIL mid_exec_refetch: got req=%b we=%b expected req=1 we=0", instr_req, reg_we); end
    run_instr(16'h0A40, cyc);
    tests++;
    if (pc !== 8'h01 || h_we !== 12'h008) begin fails++; $display("FAIL mid_exec_resume: got pc=%h we=%h expected pc=01 we=008", pc, h_we); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldi_cpi();
    test_branch();
    test_wrap();
    test_stall_illegal();
    test_halt();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
